// File: rtl/sha256_pad_unit.sv
// sha256_pad_unit: SHA-256 message padder. Takes a big-endian byte message on a
// 64-bit AXI4-Stream and emits FIPS 180-4 padded 512-bit blocks (0x80, zeros,
// 64-bit bit length) on a 512-bit AXI4-Stream; m_axis_tlast marks the final block.
// Build option: define SHA_PAD_KEEP_CHECK_EN to add the sticky err_keep output.
module sha256_pad_unit #(
    parameter int unsigned P_S_AXIS_DATA_WIDTH = 64,
    parameter int unsigned P_M_AXIS_DATA_WIDTH = 512,
    parameter int unsigned P_LEN_CNT_WIDTH     = 61
) (
    input  logic                             axi_aclk,
    input  logic                             axi_resetn,
    input  logic [P_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [P_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [P_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast
`ifdef SHA_PAD_KEEP_CHECK_EN
    ,
    output logic                             err_keep
`endif
);

    localparam int unsigned IN_BYTES  = P_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned BLK_BYTES = P_M_AXIS_DATA_WIDTH / 8;
    // Byte offset where the 64-bit length field starts in a block
    localparam int unsigned LEN_POS   = BLK_BYTES - 8;

    typedef enum logic [1:0] {
        S_FILL,
        S_SEND,
        S_EXTRA
    } state_t;

    state_t                         state, state_nxt;
    logic [2:0]                     wptr;
    logic [P_LEN_CNT_WIDTH-1:0]     byte_cnt;
    logic [P_LEN_CNT_WIDTH-1:0]     cnt_sum;
    logic                           extra;
    logic                           pad80;
    logic                           accept;
    logic [3:0]                     n_keep;
    int unsigned                    base;
    int unsigned                    n_u;
    int unsigned                    u_pos;
    logic [P_S_AXIS_DATA_WIDTH-1:0] word_masked;
    logic [63:0]                    len_beat;
    logic [63:0]                    len_cur;
    logic [P_M_AXIS_DATA_WIDTH-1:0] blk_last;

    // Number of valid bytes = count of leading ones in tkeep
    function automatic logic [3:0] lead_ones(input logic [IN_BYTES-1:0] k);
        logic [3:0] c;
        logic       run;
        c   = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < IN_BYTES; i++) begin
            if (run && k[IN_BYTES-1-i]) c = c + 4'd1;
            else                        run = 1'b0;
        end
        return c;
    endfunction

    // State register
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) state <= S_FILL;
        else             state <= state_nxt;
    end

    // Next-state logic: fill until a block completes, hold it until taken,
    // insert one length-only block when the trailer did not fit
    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:  if (accept && (s_axis_tlast || wptr == 3'd7)) state_nxt = S_SEND;
            S_SEND:  if (m_axis_tready) state_nxt = extra ? S_EXTRA : S_FILL;
            S_EXTRA: state_nxt = S_SEND;
            default: state_nxt = S_FILL;
        endcase
    end

    // Beat decode and the candidate block for a tlast beat (data, 0x80, zeros, length)
    always_comb begin
        accept   = s_axis_tready & s_axis_tvalid;
        n_keep   = lead_ones(s_axis_tkeep);
        n_u      = 32'(n_keep);
        base     = 8 * 32'(wptr);
        u_pos    = base + n_u + 1;
        cnt_sum  = byte_cnt + P_LEN_CNT_WIDTH'(n_keep);
        len_beat = 64'({cnt_sum, 3'b000});
        len_cur  = 64'({byte_cnt, 3'b000});
        word_masked = '0;
        for (int unsigned j = 0; j < IN_BYTES; j++) begin
            if (j < n_u)
                word_masked[P_S_AXIS_DATA_WIDTH-1-8*j -: 8] = s_axis_tdata[P_S_AXIS_DATA_WIDTH-1-8*j -: 8];
        end
        blk_last = m_axis_tdata;
        blk_last[P_M_AXIS_DATA_WIDTH-1-P_S_AXIS_DATA_WIDTH*32'(wptr) -: P_S_AXIS_DATA_WIDTH] = word_masked;
        // Past the valid bytes: 0x80 marker then zeros (marker drops off when n=8 at wptr=7)
        for (int unsigned k = 0; k < BLK_BYTES; k++) begin
            if (k >= base + n_u)
                blk_last[P_M_AXIS_DATA_WIDTH-1-8*k -: 8] = (k == base + n_u) ? 8'h80 : 8'h00;
        end
        if (u_pos <= LEN_POS) blk_last[63:0] = len_beat;
    end

    // Datapath and registered outputs
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            wptr          <= '0;
            byte_cnt      <= '0;
            extra         <= 1'b0;
            pad80         <= 1'b0;
        end else begin
            s_axis_tready <= (state_nxt == S_FILL);
            m_axis_tvalid <= (state_nxt == S_SEND);
            case (state)
                S_FILL: begin
                    if (accept) begin
                        byte_cnt <= cnt_sum;
                        if (s_axis_tlast) begin
                            m_axis_tdata <= blk_last;
                            m_axis_tlast <= (u_pos <= LEN_POS);
                            extra        <= (u_pos > LEN_POS);
                            pad80        <= (u_pos > BLK_BYTES);
                        end else begin
                            m_axis_tdata[P_M_AXIS_DATA_WIDTH-1-P_S_AXIS_DATA_WIDTH*32'(wptr) -: P_S_AXIS_DATA_WIDTH] <= word_masked;
                            if (wptr == 3'd7) m_axis_tlast <= 1'b0;
                            else              wptr <= wptr + 3'd1;
                        end
                    end
                end
                S_SEND: begin
                    if (m_axis_tready) begin
                        wptr         <= '0;
                        m_axis_tlast <= 1'b0;
                        if (!extra && m_axis_tlast) byte_cnt <= '0;
                    end
                end
                S_EXTRA: begin
                    m_axis_tdata <= {(pad80 ? 8'h80 : 8'h00), {(P_M_AXIS_DATA_WIDTH-72){1'b0}}, len_cur};
                    m_axis_tlast <= 1'b1;
                    extra        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA_PAD_KEEP_CHECK_EN
    logic keep_bad;

    // Legal tkeep: all ones on a non-last beat, leading-ones pattern on a last beat
    always_comb begin
        keep_bad = s_axis_tlast ? (s_axis_tkeep != IN_BYTES'({IN_BYTES{1'b1}} << (4'd8 - n_keep)))
                                : (s_axis_tkeep != '1);
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn)             err_keep <= 1'b0;
        else if (accept && keep_bad) err_keep <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sha256_pad_unit.sv
// tb_sha256_pad_unit: directed and randomized bench for sha256_pad_unit.
// Expected blocks come from a byte-level padding model (message, 0x80, zeros, length).
module tb_sha256_pad_unit;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } blk_t;

    logic         axi_aclk = 1'b0;
    logic         axi_resetn = 1'b0;
    logic [63:0]  s_axis_tdata = '0;
    logic [7:0]   s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
`ifdef SHA_PAD_KEEP_CHECK_EN
    logic         err_keep;
`endif

    int   checks = 0;
    int   failures = 0;
    blk_t got_q[$];
    blk_t exp_q[$];
    blk_t mon_blk;
    logic [511:0] seen[$];
    logic rand_rdy = 1'b0;
    logic rdy_dir  = 1'b1;
    logic rdy_rand = 1'b1;

    assign m_axis_tready = rand_rdy ? rdy_rand : rdy_dir;

    sha256_pad_unit dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef SHA_PAD_KEEP_CHECK_EN
        ,
        .err_keep      (err_keep)
`endif
    );

    // Clock
    always #5 axi_aclk = ~axi_aclk;

    // Random downstream backpressure, changed just after each rising edge
    always @(posedge axi_aclk) rdy_rand <= ($urandom_range(0, 3) != 0);

    // Capture every block whose handshake completes on the next rising edge
    always @(negedge axi_aclk) begin
        if (axi_resetn && m_axis_tvalid && m_axis_tready) begin
            mon_blk.data = m_axis_tdata;
            mon_blk.last = m_axis_tlast;
            got_q.push_back(mon_blk);
        end
    end

    // Hang guard
    initial begin
        #400000;
        $display("FAIL watchdog observed=hang required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference padding: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length
    function automatic void build_expected(input byte_q_t msg);
        byte_q_t     p;
        logic [63:0] bits;
        blk_t        b;
        int unsigned nblk;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bits[63-8*i -: 8]);
        nblk = p.size() / 64;
        for (int unsigned bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int unsigned j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*bi+j];
            b.last = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endfunction

    // One beat; returns 1 ns after the accepting edge
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int unsigned n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge axi_aclk);
            n++;
        end while (!s_axis_tready && n < 1000);
        if (!s_axis_tready) check("beat_accept_timeout", 512'(s_axis_tready), 512'd1);
        @(posedge axi_aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input bit empty_tail, input bit gaps);
        int unsigned nb;
        int unsigned i;
        int unsigned c;
        logic [63:0] d;
        logic [7:0]  k;
        nb = msg.size();
        i  = 0;
        if (nb == 0) begin
            drive_beat({$urandom, $urandom}, 8'h00, 1'b1);
            return;
        end
        while (i < nb) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge axi_aclk);
                #1;
            end
            c = (nb - i >= 8) ? 8 : nb - i;
            d = {$urandom, $urandom};
            for (int unsigned j = 0; j < c; j++) d[63-8*j -: 8] = msg[i+j];
            k = 8'hFF << (8 - c);
            i += c;
            drive_beat(d, k, (i == nb) && !(empty_tail && c == 8));
        end
        if (empty_tail && nb % 8 == 0) drive_beat({$urandom, $urandom}, 8'h00, 1'b1);
    endtask

    // Wait for the expected number of blocks, then compare them in order
    task automatic collect(input string tag);
        int unsigned n;
        int unsigned want;
        blk_t e;
        blk_t g;
        n    = 0;
        want = exp_q.size();
        while (got_q.size() < want && n < 2000) begin
            @(posedge axi_aclk);
            n++;
        end
        repeat (4) @(posedge axi_aclk);
        #1;
        check({tag, "_count"}, 512'(got_q.size()), 512'(want));
        seen.delete();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, "_data"}, g.data, e.data);
            check({tag, "_last"}, 512'(g.last), 512'(e.last));
            seen.push_back(g.data);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, 512'(s_axis_tready), 512'd0);
        check({tag, "_m_tvalid"}, 512'(m_axis_tvalid), 512'd0);
        check({tag, "_m_tlast"},  512'(m_axis_tlast),  512'd0);
        check({tag, "_m_tdata"},  m_axis_tdata,        512'd0);
`ifdef SHA_PAD_KEEP_CHECK_EN
        check({tag, "_err_keep"}, 512'(err_keep), 512'd0);
`endif
    endtask

    initial begin
        byte_q_t      msg;
        logic [511:0] b0;
        logic [511:0] b1;
        int unsigned  len;
        int unsigned  edge_lens[9] = '{55, 56, 57, 63, 64, 65, 119, 120, 128};

        // Reset state
        repeat (3) @(posedge axi_aclk);
        #1;
        check_reset_outputs("reset");
        axi_resetn = 1'b1;
        #1;
        check("tready_before_edge", 512'(s_axis_tready), 512'd0);
        @(posedge axi_aclk);
        #1;
        check("tready_after_edge", 512'(s_axis_tready), 512'd1);

        // "abc" with the block held under backpressure for 5 cycles
        rdy_dir = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        build_expected(msg);
        send_msg(msg, 1'b0, 1'b0);
        check("abc_tvalid_latency", 512'(m_axis_tvalid), 512'd1);
        repeat (5) begin
            @(posedge axi_aclk);
            #1;
            check("bp_tvalid",   512'(m_axis_tvalid), 512'd1);
            check("bp_tdata",    m_axis_tdata,        exp_q[0].data);
            check("bp_tlast",    512'(m_axis_tlast),  512'd1);
            check("bp_s_tready", 512'(s_axis_tready), 512'd0);
        end
        rdy_dir = 1'b1;
        @(posedge axi_aclk);
        #1;
        check("bp_release_tvalid", 512'(m_axis_tvalid), 512'd0);
        check("bp_release_count",  512'(got_q.size()),  512'd1);
        collect("abc");
        if (seen.size() > 0) begin
            b0 = seen[0];
            check("abc_w0",  512'(b0[511:480]), 512'h61626380);
            check("abc_mid", 512'(b0[479:64]),  512'd0);
            check("abc_len", 512'(b0[63:0]),    512'h18);
        end

        // Empty message
        msg = {};
        build_expected(msg);
        send_msg(msg, 1'b0, 1'b0);
        collect("empty");
        if (seen.size() > 0) begin
            b0 = seen[0];
            check("empty_marker", 512'(b0[511:504]), 512'h80);
            check("empty_len",    512'(b0[63:0]),    512'd0);
        end

        // 56 bytes: trailer spills into a zero-marker extra block
        msg = {};
        for (int i = 1; i <= 56; i++) msg.push_back(8'(i));
        build_expected(msg);
        send_msg(msg, 1'b0, 1'b0);
        collect("b56");
        if (seen.size() > 1) begin
            b0 = seen[0];
            b1 = seen[1];
            check("b56_marker",     512'(b0[63:56]),   512'h80);
            check("b56_tail_zero",  512'(b0[55:0]),    512'd0);
            check("b56_extra_head", 512'(b1[511:64]),  512'd0);
            check("b56_extra_len",  512'(b1[63:0]),    512'h1C0);
        end

        // 64 bytes: marker lands in the extra block, which arrives 2 cycles later
        rdy_dir = 1'b0;
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
        build_expected(msg);
        send_msg(msg, 1'b0, 1'b0);
        check("b64_blk1_tvalid", 512'(m_axis_tvalid), 512'd1);
        check("b64_blk1_tlast",  512'(m_axis_tlast),  512'd0);
        rdy_dir = 1'b1;
        @(posedge axi_aclk);
        #1;
        check("b64_gap_tvalid", 512'(m_axis_tvalid), 512'd0);
        @(posedge axi_aclk);
        #1;
        check("b64_extra_tvalid", 512'(m_axis_tvalid), 512'd1);
        check("b64_extra_tlast",  512'(m_axis_tlast),  512'd1);
        collect("b64");
        if (seen.size() > 1) begin
            b1 = seen[1];
            check("b64_extra_marker", 512'(b1[511:504]), 512'h80);
            check("b64_extra_len",    512'(b1[63:0]),    512'h200);
        end

        // 64 bytes ended by a separate tkeep=00 tlast beat
        build_expected(msg);
        send_msg(msg, 1'b1, 1'b0);
        collect("b64_tail");

        // Reset after 3 beats discards the partial message
        for (int i = 0; i < 3; i++) drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        axi_resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
        got_q.delete();
        msg = '{8'h61, 8'h62, 8'h63};
        build_expected(msg);
        send_msg(msg, 1'b0, 1'b0);
        collect("abc_after_rst");
        if (seen.size() > 0) begin
            b0 = seen[0];
            check("abc_rst_w0",  512'(b0[511:480]), 512'h61626380);
            check("abc_rst_len", 512'(b0[63:0]),    512'h18);
        end

        // Randomized messages with input gaps and random backpressure
        rand_rdy = 1'b1;
        for (int m = 0; m < 30; m++) begin
            if ($urandom_range(0, 2) == 0) len = edge_lens[$urandom_range(0, 8)];
            else                           len = $urandom_range(0, 150);
            msg = {};
            for (int unsigned i = 0; i < len; i++) msg.push_back(8'($urandom));
            build_expected(msg);
            send_msg(msg, 1'($urandom_range(0, 1)), 1'b1);
            collect("rand");
        end
        rand_rdy = 1'b0;
        rdy_dir  = 1'b1;

`ifdef SHA_PAD_KEEP_CHECK_EN
        // Sticky tkeep error flag
        check("err_keep_clean", 512'(err_keep), 512'd0);
        drive_beat({$urandom, $urandom}, 8'hF0, 1'b0);
        check("err_keep_set", 512'(err_keep), 512'd1);
        drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        repeat (20) @(posedge axi_aclk);
        #1;
        got_q.delete();
        check("err_keep_sticky", 512'(err_keep), 512'd1);
        axi_resetn = 1'b0;
        #1;
        check("err_keep_reset", 512'(err_keep), 512'd0);
        @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
